// File: rtl/cska_word_seq.sv
// -----------------------------------------------------------------------------
// cska_word_seq
//   Multi-cycle wide adder. A W = N*WORDS bit add is performed by time-sharing
//   one N-bit carry-skip adder (cska_top), one slice per clock, least
//   significant slice first. The slice carry-out is registered and feeds the
//   next slice's carry-in. Operands come in on a valid/ready handshake and the
//   result leaves on a second valid/ready handshake.
//
// Ports (cska_word_seq)
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operands valid
//   in_ready   out  sequencer is idle and accepts operands
//   a, b       in   W-bit operands
//   cin        in   carry into slice 0
//   out_valid  out  result valid (held until out_ready)
//   out_ready  in   consumer accepts result
//   sum        out  W-bit registered result
//   cout       out  registered carry out of the top processed slice
//   busy       out  high whenever the sequencer is not idle
//
// Ports (cska_top)
//   a, b       in   N-bit slice operands
//   cin        in   slice carry in
//   sum        out  N-bit slice sum
//   cout       out  slice carry out
//
// Build option
//   CSKA_SEQ_EARLY_DONE_EN : when defined, RUN finishes as soon as the carry
//   into the next slice is 0 and every remaining operand slice is 0. Results
//   are identical to the default build; only latency shrinks (1..WORDS).
// -----------------------------------------------------------------------------

module cska_top #(
    parameter int N          = 2,
    parameter int BLOCK_SIZE = 2
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int NUM_BLOCKS = N / BLOCK_SIZE;

    logic blk_cin;
    logic ripple_c;
    logic blk_prop;

    // Each block ripples internally; when every bit of the block propagates,
    // the block's carry-in bypasses the ripple chain straight to the next block.
    always_comb begin
        sum      = '0;
        blk_cin  = cin;
        ripple_c = cin;
        blk_prop = 1'b1;
        for (int blk = 0; blk < NUM_BLOCKS; blk++) begin
            ripple_c = blk_cin;
            blk_prop = 1'b1;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                sum[blk*BLOCK_SIZE + i] = a[blk*BLOCK_SIZE + i] ^ b[blk*BLOCK_SIZE + i] ^ ripple_c;
                blk_prop = blk_prop & (a[blk*BLOCK_SIZE + i] ^ b[blk*BLOCK_SIZE + i]);
                ripple_c = (a[blk*BLOCK_SIZE + i] & b[blk*BLOCK_SIZE + i])
                         | ((a[blk*BLOCK_SIZE + i] ^ b[blk*BLOCK_SIZE + i]) & ripple_c);
            end
            blk_cin = blk_prop ? blk_cin : ripple_c;
        end
        cout = blk_cin;
    end

endmodule

// -----------------------------------------------------------------------------
// Sequencer states
//   state  | meaning
//   S_IDLE | waiting for operands, in_ready high
//   S_RUN  | adding slice idx_q, one slice per clock
//   S_DONE | result held, out_valid high until out_ready
// -----------------------------------------------------------------------------
module cska_word_seq #(
    parameter int N          = 2,
    parameter int BLOCK_SIZE = 2,
    parameter int WORDS      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 busy
);

    localparam int W     = N * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [W-1:0]     a_q,         a_d;
    logic [W-1:0]     b_q,         b_d;
    logic [W-1:0]     sum_q,       sum_d;
    logic             cout_q,      cout_d;
    logic             carry_q,     carry_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q,      busy_d;

    logic [31:0]      slice_base;
    logic [W-1:0]     slice_mask;
    logic [N-1:0]     slice_a;
    logic [N-1:0]     slice_b;
    logic [N-1:0]     add_sum;
    logic             add_cout;
`ifdef CSKA_SEQ_EARLY_DONE_EN
    logic             upper_zero;
`endif

    // Slice selection is done with shifts so the index arithmetic stays a
    // plain 32-bit bit offset.
    always_comb begin
        slice_base = 32'(idx_q) * 32'(N);
        slice_mask = W'({N{1'b1}}) << slice_base;
        slice_a    = N'(a_q >> slice_base);
        slice_b    = N'(b_q >> slice_base);
    end

`ifdef CSKA_SEQ_EARLY_DONE_EN
    // Remaining operand slices above the one being written are all zero.
    always_comb begin
        upper_zero = ((a_q | b_q) >> (slice_base + 32'(N))) == '0;
    end
`endif

    cska_top #(
        .N          (N),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_cska (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d   = (sum_q & ~slice_mask) | (W'(add_sum) << slice_base);
                carry_d = add_cout;
                cout_d  = add_cout;
                if (idx_q == LAST_IDX) begin
                    // idx is held on the last slice so it never wraps.
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
`ifdef CSKA_SEQ_EARLY_DONE_EN
                    // No carry leaves this slice and nothing remains above it,
                    // so the cleared upper sum slices are already correct.
                    if (!add_cout && upper_zero) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake and status outputs are registered from the next state.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cska_word_seq.sv
// Bench for cska_word_seq with N=2, BLOCK_SIZE=2, WORDS=4 (W=8).
// A transaction-level model predicts result value and latency from plain
// arithmetic; a negedge monitor compares every cycle, and directed tests pin
// literal expectations.
module tb_cska_word_seq;

    localparam int N          = 2;
    localparam int BLOCK_SIZE = 2;
    localparam int WORDS      = 4;
    localparam int W          = 8;
`ifdef CSKA_SEQ_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_en = 1'b0;

    cska_word_seq #(
        .N          (N),
        .BLOCK_SIZE (BLOCK_SIZE),
        .WORDS      (WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Latency: cycles from accept edge to the edge after which out_valid is high.
    function automatic int model_latency(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                         input logic fc);
        int           w;
        logic [W:0]   msk;
        logic [W:0]   low;
        if (!EARLY) return WORDS;
        for (int k = 1; k <= WORDS; k++) begin
            w   = N * k;
            msk = (W+1)'((1 << w) - 1);
            low = ({1'b0, fa} & msk) + ({1'b0, fb} & msk) + {{W{1'b0}}, fc};
            if (low[w] == 1'b0 && ((fa | fb) >> w) == '0) return k;
        end
        return WORDS;
    endfunction

    // ---------------- per-cycle monitor against the model ----------------
    bit         pending = 1'b0;
    int         acc_cyc = 0;
    int         exp_lat = 0;
    logic [W:0] exp_res = '0;

    always @(negedge clk) begin
        bit ov_exp;
        if (rst) begin
            chk("rst_in_ready",  32'(in_ready),  32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_busy",      32'(busy),      32'd0);
            chk("rst_sum",       32'(sum),       32'd0);
            chk("rst_cout",      32'(cout),      32'd0);
            pending = 1'b0;
        end else begin
            ov_exp = pending && ((cyc - acc_cyc) >= exp_lat);
            chk("mon_in_ready",  32'(in_ready),  32'(!pending));
            chk("mon_busy",      32'(busy),      32'(pending));
            chk("mon_out_valid", 32'(out_valid), 32'(ov_exp));
            if (ov_exp) begin
                chk("mon_sum",  32'(sum),  32'(exp_res[W-1:0]));
                chk("mon_cout", 32'(cout), 32'(exp_res[W]));
            end
            if (ov_exp && out_ready) begin
                pending = 1'b0;
            end else if (!pending && in_valid) begin
                pending = 1'b1;
                acc_cyc = cyc + 1;
                exp_res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                exp_lat = model_latency(a, b, cin);
            end
        end
    end

    // Random consumer stalls during the random phase.
    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- directed driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts just after a posedge in IDLE; returns at the negedge where
    // out_valid is first seen, with lat = edges since the accept edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          output int lat);
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= WORDS + 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) chk("op_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int lat;
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        tick();

        // Full carry ripple.
        run_op(8'hFF, 8'h01, 1'b0, lat);
        chk("ripple_lat",  32'(lat),  32'd4);
        chk("ripple_sum",  32'(sum),  32'h00);
        chk("ripple_cout", 32'(cout), 32'd1);
        tick();

        // Carry-in only.
        run_op(8'h00, 8'h00, 1'b1, lat);
        chk("cin_lat",  32'(lat),  EARLY ? 32'd1 : 32'd4);
        chk("cin_sum",  32'(sum),  32'h01);
        chk("cin_cout", 32'(cout), 32'd0);
        tick();

        // Early-done candidate.
        run_op(8'h03, 8'h01, 1'b0, lat);
        chk("early_lat",  32'(lat),  EARLY ? 32'd2 : 32'd4);
        chk("early_sum",  32'(sum),  32'h04);
        chk("early_cout", 32'(cout), 32'd0);
        tick();

        // Backpressure with ignored in_valid pulses.
        out_ready = 1'b0;
        run_op(8'hA5, 8'h5A, 1'b1, lat);
        chk("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            a        = 8'h3C;
            b        = 8'h11;
            cin      = 1'b0;
            in_valid = (i != 1);
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready",  32'(in_ready),  32'd0);
            chk("bp_sum",       32'(sum),       32'h00);
            chk("bp_cout",      32'(cout),      32'd1);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_release_busy",      32'(busy),      32'd0);
        chk("bp_release_in_ready",  32'(in_ready),  32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        tick();

        // Reset asserted asynchronously in the second RUN cycle.
        a        = 8'hFF;
        b        = 8'hFF;
        cin      = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        chk("abort_busy_before", 32'(busy), 32'd1);
        chk("abort_sum_before",  32'(sum),  32'h03);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum",       32'(sum),       32'd0);
        chk("abort_cout",      32'(cout),      32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        tick();
        rst = 1'b0;
        repeat (WORDS + 2) begin
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        tick();

        // Random operations with random consumer stalls.
        rand_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            ra       = 8'($urandom);
            rb       = 8'($urandom);
            if (i % 8 == 0) begin
                ra = ra & 8'h0F;
                rb = rb & 8'h03;
            end
            a        = ra;
            b        = rb;
            cin      = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) chk("rand_accept_timeout", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_en = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cska_word_seq.md
# cska_word_seq

Multi-cycle sequencer that performs a W = N*WORDS-bit addition by time-sharing a single N-bit `cska_top` carry-skip adder, one N-bit slice per clock, least significant slice first, with the slice carry-out registered into the next slice's carry-in. It sits between a valid/ready operand producer and a valid/ready result consumer, so wide adds can be built on the narrow, verified carry-skip datapath.

## Interface
- `N`, 2, slice width; passed to the internal `cska_top` as `N`
- `BLOCK_SIZE`, 2, skip-block size passed to `cska_top`; must divide N
- `WORDS`, 4, number of slices, ≥1; W = N*WORDS
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_valid`  in  1  operands valid
- `in_ready`  out  1  sequencer accepts operands
- `a`  in  W  operand A
- `b`  in  W  operand B
- `cin`  in  1  carry into slice 0
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `sum`  out  W  registered result
- `cout`  out  1  registered carry out of the top processed slice
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- Exactly one internal `cska_top` instance, `#(.N(N), .BLOCK_SIZE(BLOCK_SIZE))`. Its ports are driven from the registered operands, the slice index, and the carry register.
- States: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid`, latch `a`, `b`; set carry register = `cin`, `idx`=0, `sum`=0, `cout`=0; go to RUN.
- RUN: the adder sees `a_r[idx*N +: N]`, `b_r[idx*N +: N]`, and the carry register. Each cycle, write the adder sum into `sum[idx*N +: N]`, load the carry register and `cout` from the adder Cout, and increment `idx`. When `idx`==WORDS-1, go to DONE.
- DONE: `out_valid`=1. `sum` and `cout` are held stable. On `out_ready`, go to IDLE.
- `in_ready` = (state==IDLE). `in_valid` is ignored in RUN and DONE, with no queuing.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, modulo 2^(W+1). Unsigned; no overflow flag.
- `idx` is $clog2(WORDS) bits wide (1 bit minimum). It never wraps, because the RUN exit happens at WORDS-1.
- Reset (any time, including mid-RUN or DONE): state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0, `cout`=0, carry register 0, `idx`=0. An in-flight operation is discarded and no result is produced.

## Timing
- Operands are accepted at edge T, when `in_valid`&&`in_ready`.
- Slice k is written at edge T+1+k.
- `out_valid` rises after edge T+WORDS; fixed latency is WORDS cycles.
- The result handshake completes at the edge where `out_valid`&&`out_ready`. `in_ready` returns to 1 after that edge, so the next accept is at the following edge at the earliest. Throughput is one op per WORDS+2 cycles with `out_ready` held high.
- The adder path is combinational within one cycle. There are no combinational paths from inputs to outputs.

## Configuration
- `CSKA_SEQ_EARLY_DONE_EN` defined:
  - In RUN, after writing slice `idx`, compute the next carry-register value. If it is 0 and all slices above `idx` of both `a_r` and `b_r` are 0, go to DONE immediately.
  - Untouched upper `sum` slices stay 0 (cleared at accept), and `cout`=0.
  - Latency is 1..WORDS cycles.
- Not defined: RUN always processes all WORDS slices, giving fixed latency WORDS.
- The result values are identical in both builds; only latency differs.

## Test plan
All scenarios use N=2, WORDS=4, W=8.
- Full carry ripple: `a`=8'hFF, `b`=8'h01, `cin`=0 -> `sum`=8'h00, `cout`=1, `out_valid` exactly 4 cycles after accept (macro off).
- Carry-in only: `a`=8'h00, `b`=8'h00, `cin`=1 -> `sum`=8'h01, `cout`=0. Without the macro, latency is 4. With the macro, latency is 1.
- Backpressure: complete `a`=8'hA5, `b`=8'h5A, `cin`=1, then hold `out_ready`=0 for 3 cycles while pulsing `in_valid`. Required: `sum`=8'h00 and `cout`=1, both stable; `out_valid`=1; `in_ready`=0; the new operands are ignored. After `out_ready`=1 the state returns to IDLE.
- Reset mid-operation: assert `rst` asynchronously on the 2nd RUN cycle. Required: immediately `out_valid`=0, `sum`=0, `cout`=0, `busy`=0, `in_ready`=1. The aborted result never appears.
- Early done (macro on): `a`=8'h03, `b`=8'h01, `cin`=0 -> `sum`=8'h04, `cout`=0, `out_valid` 2 cycles after accept. The same stimulus with the macro off gives 4 cycles.
- Random: 200 ops with random `a`, `b`, `cin` and random `out_ready` stalls. Scoreboard each result against `a`+`b`+`cin`; in every build, latency is never greater than WORDS.
